// File: rtl/le_mask_sequencer.sv
// Retires one detector-chosen element per round from the active bitmap and emits it with its sorted rank.
// Latency: address accepted -> out_valid next cycle; output accepted -> ready for next address (or done) next cycle.
// Backpressure: addr_ready is low while an element waits in OUT; out_* hold until out_ready.
module le_mask_sequencer #(
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ELEMENT_NUM-1:0]      load_mask,
    input  logic                        addr_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] addr,
    output logic                        addr_ready,
    output logic [ELEMENT_NUM-1:0]      active_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOG2_ELEMENT_NUM-1:0] out_addr,
    output logic [ELEMENT_NUM-1:0]      out_one_hot,
    output logic [LOG2_ELEMENT_NUM:0]   out_rank,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ELEMENT_NUM-1:0]    ONE_HOT_LSB = {{(ELEMENT_NUM-1){1'b0}}, 1'b1};
    localparam logic [LOG2_ELEMENT_NUM:0] CNT_ONE     = {{LOG2_ELEMENT_NUM{1'b0}}, 1'b1};

    logic [1:0]                  state;
    logic [ELEMENT_NUM-1:0]      mask;
    logic [LOG2_ELEMENT_NUM:0]   remaining;
    logic [LOG2_ELEMENT_NUM:0]   rank;
    logic [LOG2_ELEMENT_NUM:0]   load_cnt;
    logic [ELEMENT_NUM-1:0]      addr_one_hot;
    logic                        addr_hit;

    always_comb begin
        load_cnt = '0;
        for (int i = 0; i < ELEMENT_NUM; i++) begin
            load_cnt = load_cnt + {{LOG2_ELEMENT_NUM{1'b0}}, load_mask[i]};
        end
    end

    assign addr_one_hot = ONE_HOT_LSB << addr;
    assign addr_hit     = |(mask & addr_one_hot);

    // Handshake qualifiers decode straight from the state register, so reset clears them at once.
    assign addr_ready  = (state == ST_RUN);
    assign out_valid   = (state == ST_OUT);
    assign busy        = (state == ST_RUN) || (state == ST_OUT);
    assign done        = (state == ST_DONE);
    assign active_mask = mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mask        <= '0;
            remaining   <= '0;
            rank        <= '0;
            out_addr    <= '0;
            out_one_hot <= '0;
            out_rank    <= '0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask      <= load_mask;
                        remaining <= load_cnt;
                        rank      <= '0;
                        state     <= (load_cnt == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (addr_valid) begin
                        if (addr_hit) begin
                            mask        <= mask & ~addr_one_hot;
                            out_addr    <= addr;
                            out_one_hot <= addr_one_hot;
                            out_rank    <= rank;
                            state       <= ST_OUT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        rank      <= rank + CNT_ONE;
                        remaining <= remaining - CNT_ONE;
                        state     <= (remaining == CNT_ONE) ? ST_DONE : ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/le_mask_sequencer.md
# le_mask_sequencer

Sequential address-to-one-hot side of the sorting engine's largest-element loop. It holds the active-element bitmap and accepts one largest-element address per round from the detector. For each accepted address it decodes it back to a one-hot vector, retires that bit from the bitmap, and emits the element in sorted order with its rank through a valid/ready handshake. The surviving bitmap feeds the next detection round. The block reports completion when the bitmap is empty.

## Interface
- ELEMENT_NUM, 16, number of elements; power of two.
- LOG2_ELEMENT_NUM, 4, address width, log2(ELEMENT_NUM).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that loads load_mask; ignored unless in IDLE.
- load_mask  in  ELEMENT_NUM  initial active bitmap, sampled on start.
- addr_valid  in  1  detector address valid.
- addr  in  LOG2_ELEMENT_NUM  largest-element address from the detector.
- addr_ready  out  1  address accepted when addr_valid and addr_ready are both high.
- active_mask  out  ELEMENT_NUM  registered bitmap of elements not yet retired.
- out_valid  out  1  sorted element available.
- out_ready  in  1  downstream accepts the element.
- out_addr  out  LOG2_ELEMENT_NUM  address of the emitted element.
- out_one_hot  out  ELEMENT_NUM  decoded one-hot of out_addr (bit out_addr set).
- out_rank  out  LOG2_ELEMENT_NUM+1  emission order; 0 is the first (largest) element.
- busy  out  1  high in RUN and OUT.
- done  out  1  one-cycle pulse when the bitmap is exhausted.
- err  out  1  one-cycle pulse when an address for an inactive element is rejected.

## Operation
- Internal state: state, mask, remaining (LOG2+1 bits), rank (LOG2+1 bits).
- **IDLE:** addr_ready=0, out_valid=0. On start:
  - mask<=load_mask, remaining<=popcount(load_mask), rank<=0.
  - Go to DONE if the popcount is 0, otherwise go to RUN.
- **RUN:** addr_ready=1. On an address handshake, one_hot = 1<<addr.
  - If mask & one_hot is nonzero: mask<=mask&~one_hot, out_addr<=addr, out_one_hot<=one_hot, out_rank<=rank, then go to OUT.
  - Otherwise (element already retired or never loaded): err pulses for 1 cycle, mask is unchanged, state stays RUN, and the address is dropped.
- **OUT:** out_valid=1, addr_ready=0.
  - out_addr, out_one_hot and out_rank are held stable until out_ready.
  - On the output handshake: rank<=rank+1, remaining<=remaining-1.
  - Go to DONE if remaining was 1, otherwise go to RUN.
- **DONE:** done=1 for exactly one cycle, then go to IDLE. The mask is already zero here (or zero from an empty load).
- start while busy or in DONE is ignored. load_mask bits are accepted as given, with no validity check.
- rank never exceeds ELEMENT_NUM-1 on output, so the LOG2+1 width has no wrap.
- active_mask always reflects the register mask. A retired bit reads cleared from the cycle in which OUT is entered.

## Timing
- Reset (asynchronous assert, synchronous release) forces state=IDLE and all of the following to 0: mask, active_mask, remaining, rank, out_addr, out_one_hot, out_rank, out_valid, addr_ready, busy, done, err. Reset mid-sort abandons the operation with no done pulse.
- start sampled at edge T: busy=1 and addr_ready=1 from T+1. For an empty mask, done=1 in cycle T+1.
- Address handshake at edge T: out_valid=1 and active_mask updated from T+1.
- Output handshake at edge T: addr_ready=1 again from T+1 if elements remain. Otherwise done=1 in cycle T+1, and IDLE (start accepted) from T+2.
- Peak throughput is one element per 2 cycles. Holding out_ready high is allowed.
- err is asserted in the cycle after the rejected handshake.

## Test plan
- **Full sort:** start with load_mask=16'hFFFF; addresses 15,14,…,0 with addr_valid held high; out_ready=1. Required: 16 outputs, out_rank 0..15, out_one_hot 16'h8000 down to 16'h0001, active_mask 16'h7FFF after the first acceptance, done one cycle after the 16th handshake, active_mask=0, no err.
- **Backpressure:** load_mask=16'h0003, address 1, out_ready low for 3 cycles. Required: out_valid=1, out_addr=1, out_one_hot=16'h0002 and out_rank=0 all stable; addr_ready=0 throughout; release accepted on the 4th cycle.
- **Inactive address:** load_mask=16'h00F0, address 2. Required: err pulses once, active_mask stays 16'h00F0, no out_valid. Then address 5: out_one_hot=16'h0020, active_mask=16'h00D0.
- **Empty load:** start with load_mask=0. Required: done=1 in the next cycle, busy never set, no outputs.
- **Start ignored:** pulse start with load_mask=16'hFFFF while in RUN with mask 16'h0011. Required: active_mask unchanged, sort continues to 2 outputs, then done.
- **Reset mid-sort:** assert rst_n low after 3 outputs of a 16'hFFFF sort. Required: all outputs 0 immediately, no done pulse; after release, a fresh start sorts normally from rank 0.
